// File: rtl/reverb_param_in_pio.sv
// reverb_param_in_pio: Avalon-MM input PIO with synchronizer, edge capture and maskable irq
module reverb_param_in_pio #(
    parameter int          DATA_WIDTH  = 25,
    parameter int          EDGE_TYPE   = 0,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);
    localparam logic [DATA_WIDTH-1:0] rst_val = RESET_VALUE[DATA_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] data_sync, prev, edge_det, clr;
    logic [DATA_WIDTH-1:0] irq_mask, mask_next, edge_capture, capture_next;
    logic                  wr, unused_bits;

    assign data_sync   = sync_q[SYNC_STAGES-1];
    assign wr          = chipselect & ~write_n;
    assign unused_bits = ^writedata;

    // edge select, W1C mask and next-state for mask/capture; a new edge overrides a clear
    always_comb begin
        edge_det     = EDGE_TYPE == 0 ? data_sync & ~prev :
                       EDGE_TYPE == 1 ? ~data_sync & prev : data_sync ^ prev;
        clr          = wr && address == 2'd3 ? writedata[DATA_WIDTH-1:0] : '0;
        mask_next    = wr && address == 2'd1 ? writedata[DATA_WIDTH-1:0] : irq_mask;
        capture_next = (edge_capture & ~clr) | edge_det;
    end

    // synchronizer chain and one-cycle delayed sample; both reset to the same value so no edge follows reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= rst_val;
            prev <= rst_val;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev <= data_sync;
        end
    end

    // mask, capture and irq; irq uses next-state values so it tracks the capture register without lag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask     <= '0;
            edge_capture <= '0;
            irq          <= 1'b0;
        end else begin
            irq_mask     <= mask_next;
            edge_capture <= capture_next;
            irq          <= |(capture_next & mask_next);
        end
    end

    // zero-latency read mux, independent of chipselect
    always_comb begin
        readdata = address == 2'd0 ? 32'(data_sync) :
                   address == 2'd1 ? 32'(irq_mask) :
                   address == 2'd3 ? 32'(edge_capture) : 32'd0;
    end
endmodule

// File: tb/tb_reverb_param_in_pio.sv
// tb_reverb_param_in_pio: directed checks of the input PIO in rising and any-edge modes
module tb_reverb_param_in_pio;
    localparam int DW = 25;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [DW-1:0] in_port = '0;
    logic [31:0]   rd_rise, rd_any;
    logic          irq_rise, irq_any;
    int            n_chk = 0;
    int            n_err = 0;
    int            caught = 0;
    int            x_seen = 0;

    always #5 clk = ~clk;

    reverb_param_in_pio #(.DATA_WIDTH(DW), .EDGE_TYPE(0)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_rise), .irq(irq_rise)
    );

    reverb_param_in_pio #(.DATA_WIDTH(DW), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_any), .irq(irq_any)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic rdchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, rd_rise, exp);
    endtask

    task automatic rdchk_any(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, rd_any, exp);
    endtask

    initial begin
        tick(2);
        rdchk("rst_data", 2'd0, 32'h0);
        rdchk("rst_mask", 2'd1, 32'h0);
        rdchk("rst_rsvd", 2'd2, 32'h0);
        rdchk("rst_cap", 2'd3, 32'h0);
        chk("rst_irq", 32'(irq_rise), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        in_port = 25'h5;
        tick(1);
        rdchk("lat_data_e1", 2'd0, 32'h0);
        tick(1);
        rdchk("lat_data_e2", 2'd0, 32'h5);
        rdchk("lat_cap_e2", 2'd3, 32'h0);
        tick(1);
        rdchk("lat_cap_e3", 2'd3, 32'h5);
        in_port = 25'h0;
        tick(4);
        rdchk("cap_hold", 2'd3, 32'h5);
        wr(2'd3, 32'hFFFF_FFFF);
        rdchk("cap_clear_all", 2'd3, 32'h0);

        wr(2'd1, 32'h4);
        in_port = 25'h4;
        tick(2);
        chk("irq_e2", 32'(irq_rise), 32'h0);
        tick(1);
        chk("irq_set", 32'(irq_rise), 32'h1);
        wr(2'd3, 32'h4);
        chk("irq_w1c", 32'(irq_rise), 32'h0);
        in_port = 25'h0;
        tick(4);
        in_port = 25'h1;
        tick(3);
        rdchk("cap_bit0", 2'd3, 32'h1);
        chk("irq_masked", 32'(irq_rise), 32'h0);
        wr(2'd1, 32'h1);
        chk("irq_unmask", 32'(irq_rise), 32'h1);
        wr(2'd1, 32'h0);
        chk("irq_mask0", 32'(irq_rise), 32'h0);
        rdchk("cap_kept", 2'd3, 32'h1);

        in_port = 25'h0;
        tick(4);
        in_port = 25'h1;
        tick(2);
        wr(2'd3, 32'h1);
        rdchk("set_wins", 2'd3, 32'h1);
        in_port = 25'h3;
        tick(3);
        rdchk("cap_3", 2'd3, 32'h3);
        wr(2'd3, 32'h2);
        rdchk("w1c_partial", 2'd3, 32'h1);

        wr(2'd3, 32'hFFFF_FFFF);
        in_port = 25'h100_0003;
        tick(3);
        rdchk_any("any_rise24", 2'd3, 32'h0100_0000);
        wr(2'd3, 32'h0100_0000);
        rdchk_any("any_clr24", 2'd3, 32'h0);
        in_port = 25'h3;
        tick(3);
        rdchk_any("any_fall24", 2'd3, 32'h0100_0000);
        wr(2'd0, 32'hFFFF_FFFF);
        rdchk("data_ro", 2'd0, 32'h3);
        wr(2'd2, 32'hFFFF_FFFF);
        rdchk("rsvd_zero", 2'd2, 32'h0);
        wr(2'd1, 32'hFFFF_FFFF);
        rdchk("mask_width", 2'd1, 32'h01FF_FFFF);
        wr(2'd1, 32'h0);

        wr(2'd3, 32'hFFFF_FFFF);
        in_port = 25'h0;
        tick(4);
        wr(2'd3, 32'hFFFF_FFFF);
        wr(2'd1, 32'h3);
        in_port = 25'h3;
        tick(3);
        rdchk("pre_rst_cap", 2'd3, 32'h3);
        chk("pre_rst_irq", 32'(irq_rise), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_cap", rd_rise, 32'h0);
        chk("mid_rst_irq", 32'(irq_rise), 32'h0);
        rdchk("mid_rst_data", 2'd0, 32'h0);
        rdchk("mid_rst_mask", 2'd1, 32'h0);
        in_port = 25'h0;
        tick(1);
        reset = 1'b0;
        tick(4);
        rdchk("post_rst_cap", 2'd3, 32'h0);

        for (int k = 0; k < 100; k++) begin
            #($urandom_range(0, 8));
            in_port = 25'h1;
            #10;
            in_port = 25'h0;
            tick(5);
            address = 2'd3;
            #1;
            if ($isunknown(rd_rise) || $isunknown(irq_rise)) x_seen++;
            if (rd_rise == 32'h1) caught++;
            wr(2'd3, 32'h1);
        end
        chk("pulses_caught", 32'(caught), 32'd100);
        chk("no_x", 32'(x_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
